// File: rtl/pipe_mux_pkg.sv
// Shared definitions for the pipelined select mux: buffer state encoding and
// the select-width derivation used by the top-level parameter list.
package pipe_mux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // Binary selects need clog2(N) bits, one-hot selects need one bit per channel.
  function automatic int selWidth(input int nInputs, input int oneHot);
    return (oneHot != 0) ? nInputs : $clog2(nInputs);
  endfunction

endpackage

// File: rtl/pipe_mux_skid_buf.sv
// Two-entry valid/ready buffer (main + skid). in_ready depends only on the
// registered state, so upstream never sees a combinational path from out_ready.
module skid_buf
  import pipe_mux_pkg::*;
#(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  buf_state_e    state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          accept;

  assign in_ready  = !rst && (state_q != ST_TWO);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // A drain and an accept on the same edge in ONE overwrite main directly,
  // which is what keeps full throughput without touching the skid entry.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && out_ready) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = ST_TWO;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

endmodule

// File: rtl/pipe_mux.sv
// N-way select mux with an invalid-select flag, pipelined through a skid
// buffer so the datapath select can tolerate downstream stalls.
module pipe_mux
  import pipe_mux_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int N_INPUTS   = 4,
  parameter  int SEL_ONEHOT = 0,
  localparam int SEL_W      = selWidth(N_INPUTS, SEL_ONEHOT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] selData;
  logic             selErr;
  logic [WIDTH:0]   bufOut;

  // Anything not matching exactly one channel code falls through as data 0
  // with the error flag set.
  always_comb begin
    selData = '0;
    selErr  = 1'b1;
    for (int k = 0; k < N_INPUTS; k++) begin
      if ((SEL_ONEHOT != 0) ? (in_sel == (SEL_W'(1) << k)) : (in_sel == SEL_W'(k))) begin
        selData = in_data[k*WIDTH +: WIDTH];
        selErr  = 1'b0;
      end
    end
  end

  skid_buf #(
    .DW(WIDTH + 1)
  ) uBuf (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({selErr, selData}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (bufOut),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_err  = bufOut[WIDTH];
  assign out_data = bufOut[WIDTH-1:0];

endmodule

// File: tb/tb_pipe_mux.sv
// Scoreboard bench for pipe_mux: a 3-input binary instance and a 4-input one-hot
// instance, with expected beats queued at acceptance and checked by monitors.
module tb_pipe_mux;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;

   logic [95:0]  inDataA = '0;
   logic [1:0]   inSelA = '0;
   logic         inValidA = 1'b0;
   logic         inReadyA;
   logic [31:0]  outDataA;
   logic         outErrA;
   logic         outValidA;
   logic         outReadyA = 1'b0;

   logic [127:0] inDataB = '0;
   logic [3:0]   inSelB = '0;
   logic         inValidB = 1'b0;
   logic         inReadyB;
   logic [31:0]  outDataB;
   logic         outErrB;
   logic         outValidB;
   logic         outReadyB = 1'b0;

   beat_t        qA[$];
   beat_t        qB[$];
   int           errCount = 0;
   int           checkCount = 0;
   logic         randReadyA = 1'b0;
   logic         randReadyB = 1'b0;
   logic         holdValidA, holdValidB;
   beat_t        holdA, holdB;

   pipe_mux #(.WIDTH(32), .N_INPUTS(3), .SEL_ONEHOT(0)) dutA (
      .clk(clk), .rst(rst), .in_data(inDataA), .in_sel(inSelA), .in_valid(inValidA),
      .in_ready(inReadyA), .out_data(outDataA), .out_err(outErrA), .out_valid(outValidA),
      .out_ready(outReadyA)
   );

   pipe_mux #(.WIDTH(32), .N_INPUTS(4), .SEL_ONEHOT(1)) dutB (
      .clk(clk), .rst(rst), .in_data(inDataB), .in_sel(inSelB), .in_valid(inValidB),
      .in_ready(inReadyB), .out_data(outDataB), .out_err(outErrB), .out_valid(outValidB),
      .out_ready(outReadyB)
   );

   always #5 clk = ~clk;

   // Reference behaviour for the binary select: in-range picks the channel, else error.
   function automatic beat_t modelA(input logic [1:0] sel, input logic [95:0] d);
      beat_t r;
      r.err  = 1'b1;
      r.data = '0;
      if (int'(sel) < 3) begin
         r.err  = 1'b0;
         r.data = d[int'(sel)*32 +: 32];
      end
      return r;
   endfunction

   // Reference behaviour for the one-hot select: exactly one bit set, else error.
   function automatic beat_t modelB(input logic [3:0] sel, input logic [127:0] d);
      beat_t r;
      r.err  = 1'b1;
      r.data = '0;
      if ($countones(sel) == 1) begin
         for (int k = 0; k < 4; k++) begin
            if (sel[k]) r.data = d[k*32 +: 32];
         end
         r.err = 1'b0;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Offer one beat on A and queue its expected result at the cycle it is accepted.
   task automatic applyStimulusA(input logic [1:0] sel, input logic [95:0] d, output int waits);
      logic accepted;
      accepted = 1'b0;
      waits    = 0;
      inSelA   = sel;
      inDataA  = d;
      inValidA = 1'b1;
      while (!accepted && waits < 200) begin
         @(negedge clk);
         if (inReadyA) begin
            qA.push_back(modelA(sel, d));
            accepted = 1'b1;
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
      end
      inValidA = 1'b0;
      inSelA   = 2'($urandom_range(0, 3));
      inDataA  = {$urandom, $urandom, $urandom};
      checkOutput("A accept within budget", 64'(accepted), 64'(1));
   endtask

   task automatic applyStimulusB(input logic [3:0] sel, input logic [127:0] d, output int waits);
      logic accepted;
      accepted = 1'b0;
      waits    = 0;
      inSelB   = sel;
      inDataB  = d;
      inValidB = 1'b1;
      while (!accepted && waits < 200) begin
         @(negedge clk);
         if (inReadyB) begin
            qB.push_back(modelB(sel, d));
            accepted = 1'b1;
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
      end
      inValidB = 1'b0;
      inSelB   = 4'($urandom_range(0, 15));
      inDataB  = {$urandom, $urandom, $urandom, $urandom};
      checkOutput("B accept within budget", 64'(accepted), 64'(1));
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((qA.size() != 0 || qB.size() != 0) && n < 1000) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput("scoreboard drained", 64'(qA.size() + qB.size()), 64'(0));
   endtask

   task automatic randomBurstA(input int beats);
      int w;
      logic [1:0] sel;
      logic [95:0] d;
      for (int i = 0; i < beats; i++) begin
         sel = 2'($urandom_range(0, 3));
         d   = {$urandom, $urandom, $urandom};
         applyStimulusA(sel, d, w);
         if ($urandom_range(0, 3) == 0) waitCycles(int'($urandom_range(1, 3)));
      end
   endtask

   task automatic randomBurstB(input int beats);
      int w;
      logic [3:0] sel;
      logic [127:0] d;
      for (int i = 0; i < beats; i++) begin
         if ($urandom_range(0, 1) == 0) sel = 4'(1 << $urandom_range(0, 3));
         else sel = 4'($urandom_range(0, 15));
         d = {$urandom, $urandom, $urandom, $urandom};
         applyStimulusB(sel, d, w);
         if ($urandom_range(0, 3) == 0) waitCycles(int'($urandom_range(1, 3)));
      end
   endtask

   // Random downstream stalls while the corresponding flag is raised.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randReadyA) outReadyA = 1'($urandom_range(0, 1));
         if (randReadyB) outReadyB = 1'($urandom_range(0, 1));
      end
   end

   // Monitors: pop and compare on every output transfer; while stalled the
   // presented beat must not change.
   always @(negedge clk) begin
      if (!rst && outValidA && outReadyA) begin
         checkOutput("A output has queued expectation", 64'(qA.size() != 0), 64'(1));
         if (qA.size() != 0) checkOutput("A beat data/err", 64'({outErrA, outDataA}), 64'(qA.pop_front()));
      end
      if (!rst && holdValidA) checkOutput("A stall hold", 64'({outValidA, outErrA, outDataA}), 64'({1'b1, holdA}));
      holdValidA <= !rst && outValidA && !outReadyA;
      holdA      <= {outErrA, outDataA};
   end

   always @(negedge clk) begin
      if (!rst && outValidB && outReadyB) begin
         checkOutput("B output has queued expectation", 64'(qB.size() != 0), 64'(1));
         if (qB.size() != 0) checkOutput("B beat data/err", 64'({outErrB, outDataB}), 64'(qB.pop_front()));
      end
      if (!rst && holdValidB) checkOutput("B stall hold", 64'({outValidB, outErrB, outDataB}), 64'({1'b1, holdB}));
      holdValidB <= !rst && outValidB && !outReadyB;
      holdB      <= {outErrB, outDataB};
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int w;
      int totalWaits;
      logic [95:0] d;

      waitCycles(3);
      @(negedge clk);
      checkOutput("reset in_ready gated", 64'(inReadyA), 64'(0));
      checkOutput("reset out_valid", 64'({outValidA, outValidB}), 64'(0));
      checkOutput("reset out_data", 64'(outDataA), 64'(0));
      checkOutput("reset out_err", 64'(outErrA), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("in_ready after reset", 64'({inReadyA, inReadyB}), 64'(2'b11));

      $display("[TB] directed binary selects");
      @(posedge clk);
      #1;
      outReadyA = 1'b1;
      outReadyB = 1'b1;
      applyStimulusA(2'd0, {32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000}, w);
      @(negedge clk);
      checkOutput("A one-cycle latency valid", 64'(outValidA), 64'(1));
      @(posedge clk);
      #1;
      applyStimulusA(2'd1, {32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000}, w);
      applyStimulusA(2'd3, {32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000}, w);
      applyStimulusA(2'd2, {32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000}, w);

      $display("[TB] directed one-hot selects");
      applyStimulusB(4'b0100, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000}, w);
      applyStimulusB(4'b0110, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000}, w);
      applyStimulusB(4'b0000, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000}, w);
      applyStimulusB(4'b0001, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000}, w);
      applyStimulusB(4'b1000, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000}, w);
      waitDrain();

      $display("[TB] backpressure");
      outReadyA = 1'b0;
      applyStimulusA(2'd0, {64'h0, 32'hDDDD3333}, w);
      applyStimulusA(2'd0, {64'h0, 32'hEEEE4444}, w);
      @(negedge clk);
      checkOutput("A in_ready low when full", 64'(inReadyA), 64'(0));
      checkOutput("A holds first beat", 64'(outDataA), 64'(32'hDDDD3333));
      waitCycles(3);
      outReadyA = 1'b1;
      waitDrain();

      $display("[TB] streaming counter");
      totalWaits = 0;
      for (int i = 0; i < 16; i++) begin
         d = {$urandom, $urandom, $urandom};
         d[(i % 3)*32 +: 32] = 32'(i);
         applyStimulusA(2'(i % 3), d, w);
         totalWaits += w;
      end
      checkOutput("A full throughput stalls", 64'(totalWaits), 64'(0));
      waitDrain();

      $display("[TB] random traffic with random out_ready");
      randReadyA = 1'b1;
      randReadyB = 1'b1;
      fork
         randomBurstA(150);
         randomBurstB(150);
      join
      randReadyA = 1'b0;
      randReadyB = 1'b0;
      @(posedge clk);
      #1;
      outReadyA = 1'b1;
      outReadyB = 1'b1;
      waitDrain();

      $display("[TB] reset with buffer full");
      outReadyA = 1'b0;
      applyStimulusA(2'd1, {32'h0, 32'h12345678, 32'h0}, w);
      applyStimulusA(2'd2, {32'h9ABCDEF0, 64'h0}, w);
      @(negedge clk);
      checkOutput("A full before reset", 64'(inReadyA), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;
      qA.delete();
      qB.delete();
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("reset flush out_valid", 64'(outValidA), 64'(0));
      checkOutput("reset flush out_data", 64'(outDataA), 64'(0));
      checkOutput("in_ready gated during reset", 64'(inReadyA), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      outReadyA = 1'b1;
      @(negedge clk);
      checkOutput("in_ready after reset release", 64'(inReadyA), 64'(1));
      @(posedge clk);
      #1;
      applyStimulusA(2'd1, {32'h0, 32'hBBBB1111, 32'h0}, w);
      waitDrain();

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
